// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result buffer: status bit positions, the
// stored result record and default buffer geometry.
package fpu_pkg;

  localparam int ST_EXACT     = 3;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_INEXACT   = 0;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  status;
  } fpu_result_t;

  // Range errors are overflow or underflow; other bits never count.
  function automatic logic is_range_err(input logic [3:0] status);
    return status[ST_OVERFLOW] | status[ST_UNDERFLOW];
  endfunction

endpackage

// File: rtl/fpu_rb_storage.sv
// Circular result storage with wrapping pointers and a registered head entry.
// Occupancy is owned by the caller; writes and pops are pre-qualified.
module fpu_rb_storage
  import fpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  fpu_result_t wr_result,
  input  logic        rd_en,
  output fpu_result_t head
);

  localparam int PTR_W = $clog2(DEPTH);

  fpu_result_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  fpu_result_t      head_reg;
  fpu_result_t      head_next;

  always_comb begin
    wr_ptr_next = wr_en ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = rd_en ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
  end

  // The head register tracks the entry at the next read pointer. Only when the
  // entry being written this cycle becomes the head (empty buffer, or a single
  // entry popped while writing) is the write data forwarded into it.
  always_comb begin
    if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = wr_result;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
    end
  end

  assign head = head_reg;

endmodule

// File: rtl/fpu_result_buffer.sv
// Captures one FPU result per rising edge of the completion flag into a small
// FIFO, with a ready/valid read port, drop flag and range-error counter.
module fpu_result_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                     clock100KHz,
  input  logic                     reset,
  input  logic [31:0]              data_in,
  input  logic [3:0]               status_in,
  input  logic                     done_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_data,
  output logic [3:0]               rd_status,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop_err,
  output logic [CNT_W-1:0]         ovf_cnt
);

  localparam int CNT_BITS = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] OVF_MAX = {CNT_W{1'b1}};

  logic                done_q_reg;
  logic [CNT_BITS-1:0] count_reg;
  logic [CNT_BITS-1:0] count_next;
  logic                drop_err_reg;
  logic                drop_err_next;
  logic [CNT_W-1:0]    ovf_cnt_reg;
  logic [CNT_W-1:0]    ovf_cnt_next;

  logic        capture;
  logic        pop;
  logic        is_full;
  logic        accept;
  logic        drop;
  fpu_result_t wr_result;
  fpu_result_t head;

  assign capture = done_in & ~done_q_reg;
  assign is_full = (count_reg == CNT_BITS'(DEPTH));
  assign pop     = rd_valid & rd_ready;
  // A full buffer still accepts when the head leaves on the same edge.
  assign accept  = capture & (~is_full | pop);
  assign drop    = capture & is_full & ~pop;

  assign wr_result = '{data: data_in, status: status_in};

  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + CNT_BITS'(1);
      2'b01:   count_next = count_reg - CNT_BITS'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    drop_err_next = drop_err_reg | drop;
    ovf_cnt_next  = ovf_cnt_reg;
    if (accept && is_range_err(status_in) && (ovf_cnt_reg != OVF_MAX)) begin
      ovf_cnt_next = ovf_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      done_q_reg   <= 1'b0;
      count_reg    <= '0;
      drop_err_reg <= 1'b0;
      ovf_cnt_reg  <= '0;
    end else begin
      done_q_reg   <= done_in;
      count_reg    <= count_next;
      drop_err_reg <= drop_err_next;
      ovf_cnt_reg  <= ovf_cnt_next;
    end
  end

  fpu_rb_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk       (clock100KHz),
    .rst_n     (reset),
    .wr_en     (accept),
    .wr_result (wr_result),
    .rd_en     (pop),
    .head      (head)
  );

  assign rd_valid  = (count_reg != '0);
  assign rd_data   = head.data;
  assign rd_status = head.status;
  assign count     = count_reg;
  assign full      = is_full;
  assign drop_err  = drop_err_reg;
  assign ovf_cnt   = ovf_cnt_reg;

  a_count_bound : assert property (
    @(posedge clock100KHz) disable iff (!reset) count_reg <= CNT_BITS'(DEPTH)
  );

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed table plus hand sequences for the FPU result buffer: held flag,
// ordering, full/drop, async reset, counter saturation and random stalls.
module tb_fpu_result_buffer;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic [3:0]  status_in;
  logic        done_in;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [3:0]  rd_status;
  logic [2:0]  count;
  logic        full;
  logic        drop_err;
  logic [7:0]  ovf_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_result_buffer #(.DEPTH(4), .CNT_W(8)) dut (
    .clock100KHz (clk),
    .reset       (reset_n),
    .data_in     (data_in),
    .status_in   (status_in),
    .done_in     (done_in),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_status   (rd_status),
    .count       (count),
    .full        (full),
    .drop_err    (drop_err),
    .ovf_cnt     (ovf_cnt)
  );

  typedef struct {
    logic        done;
    logic [31:0] data;
    logic [3:0]  status;
    logic        ready;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic [31:0] exp_data;
    logic [3:0]  exp_status;
    logic        exp_full;
    logic        exp_drop;
    logic [7:0]  exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic d, input logic [31:0] dat, input logic [3:0] st,
                     input logic r, input logic v, input logic [2:0] c,
                     input logic [31:0] hd, input logic [3:0] hs, input logic f,
                     input logic dr, input logic [7:0] ov);
    vec_t t;
    t = '{d, dat, st, r, v, c, hd, hs, f, dr, ov};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic capture(input logic [31:0] d, input logic [3:0] st);
    done_in = 1'b1; data_in = d; status_in = st;
    step();
    done_in = 1'b0;
    step();
  endtask

  logic [35:0] sb[$];
  logic        done_prev, prev_hold, model_drop, nd, nr, m_pop, m_cap, m_full;
  logic [35:0] prev_word;
  logic [31:0] nd_data;
  logic [3:0]  nd_st;
  int          model_ovf;

  initial begin
    reset_n = 1'b0; data_in = '0; status_in = '0; done_in = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_drop", drop_err, 0);
    check("rst_ovf", ovf_cnt, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_status", rd_status, 0);
    reset_n = 1'b1;

    // done  data  status ready | valid count head_data head_st full drop ovf
    for (int i = 0; i < 5; i++) add(1, 32'h3F800000, 4'b1000, 0, 1, 1, 32'h3F800000, 4'b1000, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'b0001, 0,  1, 1, 1, 4'b0001, 0, 0, 0);
    add(0, 0, 0, 0,        1, 1, 1, 4'b0001, 0, 0, 0);
    add(1, 2, 4'b0100, 0,  1, 2, 1, 4'b0001, 0, 0, 1);
    add(0, 0, 0, 0,        1, 2, 1, 4'b0001, 0, 0, 1);
    add(1, 3, 4'b0010, 0,  1, 3, 1, 4'b0001, 0, 0, 2);
    add(0, 0, 0, 0,        1, 3, 1, 4'b0001, 0, 0, 2);
    add(1, 4, 4'b0110, 0,  1, 4, 1, 4'b0001, 1, 0, 3);
    add(0, 0, 0, 0,        1, 4, 1, 4'b0001, 1, 0, 3);
    add(1, 32'hAA, 4'b1000, 1, 1, 4, 2, 4'b0100, 1, 0, 3);
    add(0, 0, 0, 0,        1, 4, 2, 4'b0100, 1, 0, 3);
    add(1, 5, 4'b0100, 0,  1, 4, 2, 4'b0100, 1, 1, 3);
    add(0, 0, 0, 0,        1, 4, 2, 4'b0100, 1, 1, 3);
    add(1, 6, 4'b0010, 0,  1, 4, 2, 4'b0100, 1, 1, 3);
    add(0, 0, 0, 1,        1, 3, 3, 4'b0010, 0, 1, 3);
    add(0, 0, 0, 1,        1, 2, 4, 4'b0110, 0, 1, 3);
    add(0, 0, 0, 1,        1, 1, 32'hAA, 4'b1000, 0, 1, 3);
    add(0, 0, 0, 0,        1, 1, 32'hAA, 4'b1000, 0, 1, 3);
    add(0, 0, 0, 1,        0, 0, 0, 0, 0, 1, 3);
    add(1, 7, 4'b0001, 1,  1, 1, 7, 4'b0001, 0, 1, 3);
    add(1, 7, 4'b0001, 1,  0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0,        0, 0, 0, 0, 0, 1, 3);
    add(1, 8, 4'b0001, 0,  1, 1, 8, 4'b0001, 0, 1, 3);
    add(0, 0, 0, 0,        1, 1, 8, 4'b0001, 0, 1, 3);
    add(1, 9, 4'b0100, 1,  1, 1, 9, 4'b0100, 0, 1, 4);
    add(0, 0, 0, 1,        0, 0, 0, 0, 0, 1, 4);

    foreach (vecs[i]) begin
      done_in = vecs[i].done; data_in = vecs[i].data;
      status_in = vecs[i].status; rd_ready = vecs[i].ready;
      step();
      check($sformatf("row%0d_valid", i), rd_valid, vecs[i].exp_valid);
      check($sformatf("row%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("row%0d_full", i), full, vecs[i].exp_full);
      check($sformatf("row%0d_drop", i), drop_err, vecs[i].exp_drop);
      check($sformatf("row%0d_ovf", i), ovf_cnt, vecs[i].exp_ovf);
      if (vecs[i].exp_valid) begin
        check($sformatf("row%0d_data", i), rd_data, vecs[i].exp_data);
        check($sformatf("row%0d_status", i), rd_status, vecs[i].exp_status);
      end
      $display("[TB] row %0d: done=%0b ready=%0b -> valid=%0b count=%0d data=%h st=%b",
               i, vecs[i].done, vecs[i].ready, rd_valid, count, rd_data, rd_status);
    end

    // Asynchronous reset with three entries buffered and drop_err set.
    rd_ready = 1'b0;
    capture(32'h10, 4'b0001);
    capture(32'h11, 4'b0001);
    capture(32'h12, 4'b0001);
    check("pre_reset_count", count, 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_valid", rd_valid, 0);
    check("async_rst_drop", drop_err, 0);
    check("async_rst_ovf", ovf_cnt, 0);
    $display("[TB] async reset: count=%0d valid=%0b drop=%0b", count, rd_valid, drop_err);

    // done_in already high when reset releases counts as a rising edge.
    done_in = 1'b1; data_in = 32'hCAFE; status_in = 4'b0001;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rel_count", count, 1);
    check("rel_data", rd_data, 32'hCAFE);
    check("rel_status", rd_status, 4'b0001);
    step();
    check("rel_held_count", count, 1);
    done_in = 1'b0; rd_ready = 1'b1;
    step();
    check("rel_drain_count", count, 0);
    $display("[TB] release with done high: captured %h", 32'hCAFE);

    // Range-error counter saturation.
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      capture(i, (i % 2 == 0) ? 4'b0100 : 4'b0010);
      if (i == 9) check("sat_ovf_10", ovf_cnt, 10);
    end
    check("sat_ovf", ovf_cnt, 255);
    check("sat_drop", drop_err, 0);
    check("sat_count", count, 0);
    $display("[TB] saturation: ovf_cnt=%0d drop_err=%0b", ovf_cnt, drop_err);

    // Random stalls against a queue scoreboard.
    do_reset();
    done_in = 1'b0; rd_ready = 1'b0;
    sb.delete();
    done_prev = 1'b0; prev_hold = 1'b0; prev_word = '0; model_drop = 1'b0; model_ovf = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      check("sb_valid", rd_valid, (sb.size() != 0));
      if (sb.size() != 0) check("sb_head", {rd_data, rd_status}, sb[0]);
      if (prev_hold) check("sb_stall_hold", {rd_valid, rd_data, rd_status}, {1'b1, prev_word});
      nd = ($urandom_range(0, 2) == 0);
      nr = $urandom_range(0, 1) == 1;
      nd_data = $urandom;
      nd_st = 4'b0001 << $urandom_range(0, 3);
      done_in = nd; data_in = nd_data; status_in = nd_st; rd_ready = nr;
      m_pop  = (sb.size() != 0) && nr;
      m_cap  = nd && !done_prev;
      m_full = (sb.size() == 4);
      prev_hold = (sb.size() != 0) && !nr;
      prev_word = (sb.size() != 0) ? sb[0] : '0;
      if (m_cap && m_full && !m_pop) model_drop = 1'b1;
      if (m_pop) void'(sb.pop_front());
      if (m_cap && (!m_full || m_pop)) begin
        sb.push_back({nd_data, nd_st});
        if ((nd_st[2] || nd_st[1]) && model_ovf < 255) model_ovf++;
      end
      done_prev = nd;
      step();
    end
    check("sb_final_count", count, sb.size());
    check("sb_final_drop", drop_err, model_drop);
    check("sb_final_ovf", ovf_cnt, model_ovf);
    $display("[TB] random stall: final count=%0d drop=%0b ovf=%0d", count, drop_err, ovf_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
